// File: rtl/axis_packet_fifo_sc.sv
// axis_packet_fifo_sc: store-and-forward AXI-stream packet FIFO with a per-packet sideband word
module axis_packet_fifo_sc #(
   parameter int DSIZE        = 24,
   parameter int CSIZE        = 1,
   parameter int DEPTH        = 2,
   parameter int MAX_DATA_LEN = 16384,
   parameter int LSIZE        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DSIZE-1:0] s_tdata,
   input  logic             s_tvalid,
   input  logic             s_tlast,
   input  logic [CSIZE-1:0] s_cdata,
   output logic             s_tready,
   output logic [DSIZE-1:0] m_tdata,
   output logic             m_tvalid,
   output logic             m_tlast,
   output logic [CSIZE-1:0] m_cdata,
   input  logic             m_tready
);
   localparam int PD  = DEPTH < 4 ? 4 : DEPTH;
   localparam int PAW = $clog2(PD);
   localparam int DAW = $clog2(MAX_DATA_LEN);
   logic [DSIZE-1:0] dmem [MAX_DATA_LEN];
   logic [DAW-1:0]   dwp, drp;
   logic [DAW:0]     dcnt;
   logic [LSIZE-1:0] plen [PD];
   logic [CSIZE-1:0] pcd  [PD];
   logic [PAW-1:0]   pwp, prp;
   logic [PAW:0]     pcnt;
   logic [LSIZE-1:0] w_cnt, r_cnt;
   logic s_acc, m_acc, s_end, m_end, data_full, data_empty, pkt_full, pkt_empty;
   // Handshakes, conservative full flags and FWFT heads of both FIFOs
   always_comb begin
      data_full  = dcnt == (DAW+1)'(MAX_DATA_LEN);
      data_empty = dcnt == '0;
      pkt_full   = pcnt == (PAW+1)'(PD);
      pkt_empty  = pcnt == '0;
      s_tready   = !rst && !pkt_full && !data_full;
      m_tvalid   = !pkt_empty && !data_empty;
      m_tdata    = dmem[drp];
      m_cdata    = pcd[prp];
      m_tlast    = m_tvalid && (r_cnt == plen[prp]);
      s_acc      = s_tvalid && s_tready;
      m_acc      = m_tvalid && m_tready;
      s_end      = s_acc && s_tlast;
      m_end      = m_acc && m_tlast;
   end
   // Storage writes: one data entry per accepted beat, one record per accepted last beat
   always_ff @(posedge clk) begin
      if (s_acc) dmem[dwp] <= s_tdata;
      if (s_end) begin
         plen[pwp] <= w_cnt;
         pcd[pwp]  <= s_cdata;
      end
   end
   // Pointers, occupancy counts and beat counters; record pointers wrap at the non-power-of-two depth
   always_ff @(posedge clk) begin
      if (rst) begin
         dwp   <= '0;
         drp   <= '0;
         dcnt  <= '0;
         pwp   <= '0;
         prp   <= '0;
         pcnt  <= '0;
         w_cnt <= '0;
         r_cnt <= '0;
      end else begin
         dwp   <= s_acc ? dwp + 1'b1 : dwp;
         drp   <= m_acc ? drp + 1'b1 : drp;
         dcnt  <= dcnt + (DAW+1)'(s_acc) - (DAW+1)'(m_acc);
         pwp   <= s_end ? (pwp == PAW'(PD-1) ? '0 : pwp + 1'b1) : pwp;
         prp   <= m_end ? (prp == PAW'(PD-1) ? '0 : prp + 1'b1) : prp;
         pcnt  <= pcnt + (PAW+1)'(s_end) - (PAW+1)'(m_end);
         w_cnt <= s_end ? '0 : s_acc ? w_cnt + 1'b1 : w_cnt;
         r_cnt <= m_end ? '0 : m_acc ? r_cnt + 1'b1 : r_cnt;
      end
   end
endmodule

// File: tb/tb_axis_packet_fifo_sc.sv
// tb_axis_packet_fifo_sc: directed and randomised checks of the packet FIFO
module tb_axis_packet_fifo_sc;
   logic        clk = 1'b0, rst = 1'b1;
   logic [23:0] s_tdata = '0, m_tdata;
   logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
   logic [0:0]  s_cdata = '0, m_cdata;
   logic        m_tvalid, m_tlast, m_tready = 1'b0;
   int checks = 0, errors = 0;
   typedef struct packed {logic [23:0] d; logic l; logic c;} beat_t;
   beat_t q[$];
   beat_t e;
   int pk, bt, ln, cyc, n_in, n_out;
   logic [23:0] cd;
   logic cc;

   always #5 clk = ~clk;

   axis_packet_fifo_sc #(.DSIZE(24), .CSIZE(1), .DEPTH(2), .MAX_DATA_LEN(16), .LSIZE(16)) dut (
      .clk(clk), .rst(rst),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_cdata(s_cdata), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_cdata(m_cdata), .m_tready(m_tready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state
      tick(); tick();
      #1;
      chk("rst_m_tvalid", 32'(m_tvalid), 0);
      chk("rst_m_tlast", 32'(m_tlast), 0);
      chk("rst_s_tready", 32'(s_tready), 0);
      tick();
      rst = 1'b0;
      #1;
      chk("idle_s_tready", 32'(s_tready), 1);
      // 1: four-beat packet, visible only after its last beat
      m_tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         s_tvalid = 1'b1; s_tdata = 24'(8'h11 * (i + 1)); s_tlast = (i == 3); s_cdata = 1'b1;
         #1;
         chk("t1_early_valid", 32'(m_tvalid), 0);
      end
      tick();
      s_tvalid = 1'b0; s_tlast = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t1_valid", 32'(m_tvalid), 1);
         chk("t1_data", 32'(m_tdata), 32'(8'h11 * (i + 1)));
         chk("t1_last", 32'(m_tlast), 32'(i == 3));
         chk("t1_cdata", 32'(m_cdata), 1);
         tick();
      end
      #1;
      chk("t1_drained", 32'(m_tvalid), 0);
      // 2: single-beat packet
      tick();
      s_tvalid = 1'b1; s_tdata = 24'hAB; s_tlast = 1'b1; s_cdata = 1'b0;
      tick();
      s_tvalid = 1'b0; s_tlast = 1'b0;
      #1;
      chk("t2_valid", 32'(m_tvalid), 1);
      chk("t2_data", 32'(m_tdata), 32'hAB);
      chk("t2_last", 32'(m_tlast), 1);
      chk("t2_cdata", 32'(m_cdata), 0);
      tick();
      #1;
      chk("t2_drained", 32'(m_tvalid), 0);
      // 3: record FIFO fills at four packets, fifth is held then accepted
      m_tready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         s_tvalid = 1'b1; s_tdata = 24'(k); s_tlast = 1'b1; s_cdata = 1'(k);
         #1;
         chk("t3_ready_fill", 32'(s_tready), 1);
      end
      tick();
      s_tdata = 24'd5; s_cdata = 1'b1;
      #1;
      chk("t3_full", 32'(s_tready), 0);
      tick(); tick();
      chk("t3_still_full", 32'(s_tready), 0);
      m_tready = 1'b1;
      for (int j = 1; j <= 5; j++) begin
         #1;
         chk("t3_valid", 32'(m_tvalid), 1);
         chk("t3_data", 32'(m_tdata), 32'(j));
         chk("t3_last", 32'(m_tlast), 1);
         chk("t3_cdata", 32'(m_cdata), 32'(j % 2));
         if (j == 1) chk("t3_conservative", 32'(s_tready), 0);
         if (j == 2) chk("t3_unblocked", 32'(s_tready), 1);
         tick();
         if (j == 2) begin s_tvalid = 1'b0; s_tlast = 1'b0; end
      end
      #1;
      chk("t3_drained", 32'(m_tvalid), 0);
      // 4: 16-beat packet fills the 16-entry data FIFO exactly
      m_tready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         s_tvalid = 1'b1; s_tdata = 24'(256 + i); s_tlast = (i == 15); s_cdata = 1'b1;
         #1;
         chk("t4_ready", 32'(s_tready), 1);
      end
      tick();
      s_tvalid = 1'b0; s_tlast = 1'b0;
      #1;
      chk("t4_data_full", 32'(s_tready), 0);
      chk("t4_valid", 32'(m_tvalid), 1);
      m_tready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         #1;
         chk("t4_data", 32'(m_tdata), 32'(256 + i));
         chk("t4_last", 32'(m_tlast), 32'(i == 15));
         tick();
      end
      #1;
      chk("t4_drained", 32'(m_tvalid), 0);
      chk("t4_ready_after", 32'(s_tready), 1);
      // 5: 100 random packets, random valid/ready, scoreboard comparison
      pk = 0; bt = 0; cyc = 0; n_in = 0; n_out = 0;
      ln = $urandom_range(1, 9); cc = 1'($urandom); cd = 24'($urandom);
      tick();
      while ((pk < 100 || q.size() != 0) && cyc < 20000) begin
         s_tvalid = (pk < 100) && ($urandom_range(0, 1) == 1);
         s_tdata = cd; s_tlast = (bt == ln - 1); s_cdata = cc;
         m_tready = ($urandom_range(0, 1) == 1);
         #1;
         if (m_tvalid && m_tready) begin
            chk("t5_no_spurious", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               n_out++;
               chk("t5_data", 32'(m_tdata), 32'(e.d));
               chk("t5_last", 32'(m_tlast), 32'(e.l));
               chk("t5_cdata", 32'(m_cdata), 32'(e.c));
            end
         end
         if (s_tvalid && s_tready) begin
            e.d = cd; e.l = s_tlast; e.c = cc;
            q.push_back(e);
            n_in++;
            if (s_tlast) begin
               pk++; bt = 0; ln = $urandom_range(1, 9); cc = 1'($urandom);
            end else bt++;
            cd = 24'($urandom);
         end
         tick();
         cyc++;
      end
      s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
      chk("t5_no_timeout", 32'(cyc < 20000), 1);
      chk("t5_beat_count", 32'(n_out), 32'(n_in));
      #1;
      chk("t5_drained", 32'(m_tvalid), 0);
      // 6: reset mid-packet drops the partial packet
      m_tready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         s_tvalid = 1'b1; s_tdata = 24'hA1 + 24'(i); s_tlast = 1'b0; s_cdata = 1'b1;
      end
      tick();
      s_tvalid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; m_tready = 1'b1;
      #1;
      chk("t6_after_rst_valid", 32'(m_tvalid), 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         s_tvalid = 1'b1; s_tdata = 24'hB1 + 24'(i); s_tlast = (i == 1); s_cdata = 1'b0;
         #1;
         chk("t6_hidden", 32'(m_tvalid), 0);
      end
      tick();
      s_tvalid = 1'b0; s_tlast = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("t6_valid", 32'(m_tvalid), 1);
         chk("t6_data", 32'(m_tdata), 32'hB1 + 32'(i));
         chk("t6_last", 32'(m_tlast), 32'(i == 1));
         tick();
      end
      #1;
      chk("t6_drained", 32'(m_tvalid), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
